// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg: state encoding, default field widths and step-index width helper
package reset_sequencer_pkg;
    localparam int LW_DEF = 16;
    localparam int TW_DEF = 32;
    localparam int RW_DEF = 4;
    typedef enum logic [3:0] {
        IDLE,
        NEXT_CHECK,
        WAITREADY,
        DELAY,
        PULSE,
        WAITDONE,
        ADVANCE,
        FAULT,
        COMPLETE
    } state_t;
    function automatic int step_width(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: control/status bundle between the register bank and the reset sequencer
//   master: register bank side; drives start, abort and the per-step configuration, reads status
//   slave:  sequencer side; reads configuration, drives resetout/done/donestrobe/error/busy/alldone/curstep/retrycnt
interface reset_sequencer_if
    import reset_sequencer_pkg::*;
#(
    parameter int NSTEP = 4,
    parameter int LW = LW_DEF,
    parameter int TW = TW_DEF,
    parameter int RW = RW_DEF
);
    localparam int SW = step_width(NSTEP);
    logic start;
    logic abort;
    logic [NSTEP-1:0] stepen;
    logic [NSTEP-1:0] readycriteria;
    logic [NSTEP-1:0] donecriteria;
    logic [NSTEP*LW-1:0] readylength;
    logic [NSTEP*LW-1:0] resetlength;
    logic [NSTEP*TW-1:0] timeout;
    logic [NSTEP*RW-1:0] maxretry;
    logic [NSTEP-1:0] resetout;
    logic [NSTEP-1:0] done;
    logic [NSTEP-1:0] donestrobe;
    logic [NSTEP-1:0] error;
    logic busy;
    logic alldone;
    logic [SW-1:0] curstep;
    logic [RW-1:0] retrycnt;
    modport master (
        output start, abort, stepen, readycriteria, donecriteria, readylength, resetlength, timeout, maxretry,
        input  resetout, done, donestrobe, error, busy, alldone, curstep, retrycnt
    );
    modport slave (
        input  start, abort, stepen, readycriteria, donecriteria, readylength, resetlength, timeout, maxretry,
        output resetout, done, donestrobe, error, busy, alldone, curstep, retrycnt
    );
endinterface

// File: rtl/seq_counter.sv
// seq_counter: saturating interval counter with clear, enable and compare-equal
//   clk, rst_n: clock, asynchronous active-low reset
//   clr: zero the count; en: count up (held at all-ones); cmp: compare value; eq: count == cmp
module seq_counter #(
    parameter int TW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [TW-1:0] cmp,
    output logic          eq
);
    logic [TW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != '1)
            cnt <= cnt + 1'b1;
    end
    assign eq = cnt == cmp;
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: walks NSTEP reset steps (ready wait, delay, reset pulse, done wait with timeout)
//   clk, rst_n: clock, asynchronous active-low reset
//   bus (slave): start/abort, per-step enable/criteria/lengths/timeouts/retries in; resetout, done,
//                donestrobe, error, busy, alldone, curstep, retrycnt out (all registered)
//   RESET_SEQUENCER_RETRY_EN: when defined, a timed-out step is retried up to its maxretry count
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NSTEP = 4,
    parameter int LW = LW_DEF,
    parameter int TW = TW_DEF,
    parameter int RW = RW_DEF
) (
    input logic clk,
    input logic rst_n,
    reset_sequencer_if.slave bus
);
    localparam int SW = step_width(NSTEP);
    localparam logic [SW-1:0] LAST = SW'(NSTEP - 1);
    state_t state, state_n;
    logic start_r, start_q, start_edge;
    logic [SW-1:0] curstep, curstep_n;
    logic [NSTEP-1:0] resetout, resetout_n;
    logic [NSTEP-1:0] done, done_n;
    logic [NSTEP-1:0] donestrobe, donestrobe_n;
    logic [NSTEP-1:0] error, error_n;
    logic busy, busy_n, alldone, alldone_n;
    logic [TW-1:0] tmo, cmp;
    logic cnt_eq, timed_out, retry_ok;
    // start passes through one register before edge detection
    assign start_edge = start_r & ~start_q;
    assign tmo = bus.timeout[curstep*TW +: TW];
    assign cmp = state == DELAY ? TW'(bus.readylength[curstep*LW +: LW]) :
                 state == PULSE ? TW'(bus.resetlength[curstep*LW +: LW]) : tmo;
    assign timed_out = tmo != '0 && cnt_eq;
    // one counter times all three intervals; it restarts on every state change
    seq_counter #(.TW(TW)) u_cnt (
        .clk(clk),
        .rst_n(rst_n),
        .clr(state_n != state),
        .en(state inside {DELAY, PULSE, WAITDONE}),
        .cmp(cmp),
        .eq(cnt_eq)
    );
`ifdef RESET_SEQUENCER_RETRY_EN
    logic [RW-1:0] retrycnt;
    assign retry_ok = retrycnt < bus.maxretry[curstep*RW +: RW];
    // NEXT_CHECK is only entered via a start edge or a step advance, both of which reset the count;
    // WAITDONE -> WAITREADY only happens on a retry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retrycnt <= '0;
        else if (state_n == NEXT_CHECK)
            retrycnt <= '0;
        else if (state == WAITDONE && state_n == WAITREADY)
            retrycnt <= retrycnt + 1'b1;
    end
    assign bus.retrycnt = retrycnt;
`else
    logic unused_maxretry;
    assign unused_maxretry = ^bus.maxretry;
    assign retry_ok = 1'b0;
    assign bus.retrycnt = RW'(0);
`endif
    always_comb begin
        state_n = state;
        curstep_n = curstep;
        done_n = done;
        error_n = error;
        alldone_n = alldone;
        donestrobe_n = '0;
        case (state)
            NEXT_CHECK: begin
                state_n = bus.stepen[curstep] ? WAITREADY : ADVANCE;
                done_n[curstep] = done[curstep] | ~bus.stepen[curstep];
            end
            WAITREADY: state_n = bus.readycriteria[curstep] ? DELAY : WAITREADY;
            DELAY: state_n = cnt_eq ? PULSE : DELAY;
            PULSE: state_n = cnt_eq ? WAITDONE : PULSE;
            WAITDONE: begin
                // done takes priority over a timeout in the same cycle
                if (bus.donecriteria[curstep]) begin
                    done_n[curstep] = 1'b1;
                    donestrobe_n[curstep] = 1'b1;
                    state_n = ADVANCE;
                end else if (timed_out) begin
                    state_n = retry_ok ? WAITREADY : FAULT;
                    error_n[curstep] = error[curstep] | ~retry_ok;
                end
            end
            ADVANCE: begin
                state_n = curstep == LAST ? COMPLETE : NEXT_CHECK;
                curstep_n = curstep == LAST ? curstep : curstep + 1'b1;
                alldone_n = alldone | (curstep == LAST);
            end
            default: ;
        endcase
        if (start_edge) begin
            state_n = NEXT_CHECK;
            curstep_n = '0;
            done_n = '0;
            error_n = '0;
            alldone_n = 1'b0;
            donestrobe_n = '0;
        end
        // abort beats a coincident start edge and keeps the completion history
        if (bus.abort) begin
            state_n = IDLE;
            curstep_n = curstep;
            done_n = done;
            error_n = error;
            alldone_n = alldone;
            donestrobe_n = '0;
        end
        resetout_n = '0;
        resetout_n[curstep_n] = state_n == PULSE;
        busy_n = !(state_n inside {IDLE, FAULT, COMPLETE});
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            start_r <= 1'b0;
            start_q <= 1'b0;
            curstep <= '0;
            resetout <= '0;
            done <= '0;
            donestrobe <= '0;
            error <= '0;
            busy <= 1'b0;
            alldone <= 1'b0;
        end else begin
            state <= state_n;
            start_r <= bus.start;
            start_q <= start_r;
            curstep <= curstep_n;
            resetout <= resetout_n;
            done <= done_n;
            donestrobe <= donestrobe_n;
            error <= error_n;
            busy <= busy_n;
            alldone <= alldone_n;
        end
    end
    assign bus.resetout = resetout;
    assign bus.done = done;
    assign bus.donestrobe = donestrobe;
    assign bus.error = error;
    assign bus.busy = busy;
    assign bus.alldone = alldone;
    assign bus.curstep = curstep;
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised multi-step reset sequencer for the board bring-up chain, the successor to the single-pass chained reset block. It walks NSTEP reset steps in ascending index order: wait for a readiness condition, wait a programmable delay, drive a programmable-width reset pulse, then wait for a done condition under a timeout. It adds per-step enable/skip, bounded automatic retry on timeout, an abort input, and live progress status. It sits between the control register bank and the per-subsystem reset inputs (DAC/ADC/PLL/transceiver).

## Interface
- NSTEP, 4: number of steps, 1..64
- LW, 16: width of each readylength/resetlength field
- TW, 32: width of each timeout field
- RW, 4: width of each maxretry field and of retrycnt
- SW, derived: max(1, $clog2(NSTEP)), width of curstep

- clk  in  1  sequencer clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  rising edge (re)starts the sequence from step 0
- abort  in  1  level; stops the sequence
- stepen  in  NSTEP  per-step enable; 0 = skip step
- readycriteria  in  NSTEP  step may begin when bit high
- donecriteria  in  NSTEP  step complete when bit high
- readylength  in  NSTEP*LW  pre-pulse delay per step
- resetlength  in  NSTEP*LW  pulse length per step
- timeout  in  NSTEP*TW  done timeout per step; 0 = wait forever
- maxretry  in  NSTEP*RW  retries allowed per step
- resetout  out  NSTEP  reset pulse per step
- done  out  NSTEP  sticky per-step complete
- donestrobe  out  NSTEP  one-cycle pulse at step completion
- error  out  NSTEP  sticky per-step failure
- busy  out  1  sequence in progress
- alldone  out  1  all steps complete
- curstep  out  SW  index of active step
- retrycnt  out  RW  retries used by active step

## Operation
- All outputs registered; all reset to 0 on rst_n low.
- start edge: start registered once; edge = start & ~start_q. Edge clears done, error, alldone, retrycnt, sets curstep=0, enters NEXT_CHECK. Edge overrides every state.
- abort high: state→IDLE next cycle, resetout cleared, busy=0; done/error retained. abort and start edge in same cycle: abort wins.
- States:
  - IDLE: wait for start edge.
  - NEXT_CHECK: stepen[curstep]=0 → set done[curstep] (no donestrobe), ADVANCE; else WAITREADY.
  - WAITREADY: readycriteria[curstep]=1 → DELAY.
  - DELAY: readylength+1 cycles → PULSE.
  - PULSE: resetout[curstep]=1 for resetlength+1 cycles → WAITDONE.
  - WAITDONE: donecriteria=1 → set done, pulse donestrobe, ADVANCE. Else timeout≠0 and cnt==timeout: retrycnt<maxretry → retrycnt+1, WAITREADY; else FAULT.
  - ADVANCE: curstep==NSTEP-1 → COMPLETE; else curstep+1, retrycnt=0, NEXT_CHECK.
  - FAULT: error[curstep]=1, busy=0; later steps not run; hold until start edge.
  - COMPLETE: alldone=1, busy=0; hold until start edge.
- cnt: TW bits, zeroed on every state change, +1 per cycle in DELAY/PULSE/WAITDONE; saturates, never wraps.
- donecriteria and timeout same cycle: done wins. donecriteria high already on WAITDONE entry: done on first WAITDONE cycle.
- Field selection: field i at bits [i*W +: W]; inputs sampled live each cycle.

## Timing
- start edge at cycle 0 → busy=1 at cycle 2, WAITREADY at cycle 3 (if enabled, NEXT_CHECK at cycle 2).
- readycriteria high in WAITREADY → resetout rises readylength+2 cycles later, high resetlength+1 cycles.
- donestrobe exactly 1 cycle, same edge done bit sets.
- Skipped step costs 2 cycles (NEXT_CHECK, ADVANCE).
- busy=1 in all states except IDLE, FAULT, COMPLETE.

## Configuration
- RESET_SEQUENCER_RETRY_EN defined: retry behaviour as above; retrycnt live.
- Undefined: maxretry ignored, timeout goes straight to FAULT, retrycnt tied 0, retry counter not synthesised.

## Structure
- Package reset_sequencer_pkg: state encodings (IDLE, NEXT_CHECK, WAITREADY, DELAY, PULSE, WAITDONE, ADVANCE, FAULT, COMPLETE, 4-bit), default widths LW/TW/RW.
- One sub-module seq_counter: TW-bit saturating counter with clear, enable, and compare-equal output; used for all three intervals.

## Test plan
- NSTEP=4, all enabled, readylength=2, resetlength=3, done criteria tied 1 → each resetout high 4 cycles, 4 donestrobes, alldone=1.
- stepen=4'b1011 → done[2] set without donestrobe[2], resetout[2] never asserts, alldone=1.
- Step 1 timeout=10, maxretry=2, donecriteria[1]=0 → 3 pulses on resetout[1], retrycnt 0→2, error[1]=1, steps 2-3 untouched (RETRY_EN); macro off → 1 pulse then error[1].
- Step 2 donecriteria rises on the cycle cnt==timeout → done[2], no retry, no error.
- abort mid-PULSE on step 1 → resetout[1] low next cycle, busy=0, done[0] kept; start edge → done cleared, restart at step 0.
- rst_n low mid-WAITDONE → all outputs 0 immediately, asynchronous.
